conv_encoder: RTL

//  Rate-1/2 convolutional encoder, zero-tail terminated, directly upstream of the 4x4 block interleaver.

---
 rtl/conv_encoder_pkg.sv | 22 ++
 rtl/conv_enc_core.sv | 35 +++
 rtl/conv_encoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/conv_encoder_pkg.sv
// Shared code constants for the rate-1/2 zero-tail convolutional encoder.
// Holds constraint length, generators, tail length, frame length helper and FSM states.
// No logic; imported by the encoder top and its shift-register core.
package conv_code_pkg;

   localparam int K = 3;
   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;
   localparam int TAIL_LEN = K - 1;

   // Two coded bits per step; the tail steps flush the encoder back to state zero.
   function automatic int code_len(input int info_len);
      return 2 * (info_len + TAIL_LEN);
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      EMIT
   } state_t;

endpackage

// File: rtl/conv_enc_core.sv
// Encoder shift register and parity taps for one rate-1/2 step.
// Coded bit is combinational from u and sr; sr advances on the odd phase of a step.
// No handshake: the caller qualifies every step with step/phase.
module conv_enc_core
   import conv_code_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic step,
   input  logic phase,
   input  logic u,
   output logic coded
);

   logic [K-2:0] sr;
   logic [K-1:0] win;

   assign win = {u, sr};

   // Parity of the tapped window: G0 on the even phase, G1 on the odd phase.
   assign coded = phase ? ^(G1 & win) : ^(G0 & win);

   // Shift the current input into the state once both coded bits of the step have been produced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else if (clr) begin
         sr <= '0;
      end else if (step && phase) begin
         sr <= win[K-1:1];
      end
   end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 zero-tail convolutional encoder: buffers INFO_LEN info bits, then emits CODE_LEN coded bits.
// First coded bit is launched on the edge after the last info bit is accepted; one bit per clock after that.
// ready_o is low for the whole emission so the output frame is never stalled or interrupted.
module conv_encoder
   import conv_code_pkg::*;
#(
   parameter int INFO_LEN = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic data_i,
   input  logic valid_i,
   output logic ready_o,
   output logic data_o,
   output logic valid_o,
   output logic sof_o
);

   localparam int CODE_LEN = code_len(INFO_LEN);
   localparam int CW = (INFO_LEN > 1) ? $clog2(INFO_LEN) : 1;
   localparam int JW = $clog2(CODE_LEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(INFO_LEN - 1);
   localparam logic [JW-1:0] J_LAST = JW'(CODE_LEN - 1);

   state_t state, state_d;
   logic [INFO_LEN-1:0] info_buf;
   logic [CW-1:0] cnt;
   logic [JW-1:0] j;
   logic [JW-2:0] step_idx;
   logic accept;
   logic u;
   logic coded;

   assign accept = (state == LOAD) && valid_i && ready_o;
   assign step_idx = j[JW-1:1];

   // Info bit for the current step; tail steps beyond the buffer feed zeros.
   always_comb begin
      u = 1'b0;
      for (int k = 0; k < INFO_LEN; k++) begin
         if (step_idx == k[JW-2:0]) begin
            u = info_buf[k];
         end
      end
   end

   // Next-state logic: load a full frame, emit it, return to loading.
   always_comb begin
      state_d = state;
      case (state)
         IDLE: state_d = LOAD;
         LOAD: if (accept && cnt == CNT_LAST) state_d = EMIT;
         EMIT: if (j == J_LAST) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   // State register, info buffer, counters and registered ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         info_buf <= '0;
         cnt      <= '0;
         j        <= '0;
         ready_o  <= 1'b0;
      end else begin
         state   <= state_d;
         ready_o <= (state_d == LOAD);
         if (accept) begin
            info_buf[cnt] <= data_i;
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         end
         if (state == EMIT) begin
            j <= (j == J_LAST) ? '0 : j + 1'b1;
         end
      end
   end

   // Registered coded output; forced to zero outside emission.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_o  <= 1'b0;
         valid_o <= 1'b0;
         sof_o   <= 1'b0;
      end else if (state == EMIT) begin
         data_o  <= coded;
         valid_o <= 1'b1;
         sof_o   <= (j == '0);
      end else begin
         data_o  <= 1'b0;
         valid_o <= 1'b0;
         sof_o   <= 1'b0;
      end
   end

   conv_enc_core u_core (
      .clk   (clk),
      .rst   (rst),
      .clr   (state != EMIT),
      .step  (state == EMIT),
      .phase (j[0]),
      .u     (u),
      .coded (coded)
   );

endmodule
